// File: rtl/rv_pkg.sv
// Shared RV32IM definitions: field widths, opcode constants, instruction formats
// and the loader state encoding.
package rv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OP_W     = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned FUNCT7_W = 7;
    localparam int unsigned ADDR_W   = 5;

    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;
    localparam logic [OP_W-1:0] OP_FENCE  = 7'b0001111;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } instr_fmt_t;

    typedef enum logic [1:0] {
        StIdle, StLoad, StFull, StError
    } load_state_t;

    function automatic instr_fmt_t opcode_fmt(input logic [OP_W-1:0] op);
        instr_fmt_t fmt;
        case (op)
            OP_R:                                              fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:     fmt = FMT_I;
            OP_STORE:                                          fmt = FMT_S;
            OP_BRANCH:                                         fmt = FMT_B;
            OP_LUI, OP_AUIPC:                                  fmt = FMT_U;
            OP_JAL:                                            fmt = FMT_J;
            default:                                           fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational packer: decoded fields plus format select -> 32-bit instruction word.
module rv_instr_pack
    import rv_pkg::*;
(
    input  logic [OP_W-1:0]     opcode_i,
    input  logic [FUNCT3_W-1:0] funct3_i,
    input  logic [FUNCT7_W-1:0] funct7_i,
    input  logic [ADDR_W-1:0]   rs1_i,
    input  logic [ADDR_W-1:0]   rs2_i,
    input  logic [ADDR_W-1:0]   rd_i,
    input  logic [XLEN-1:0]     imm_i,
    input  instr_fmt_t          fmt_i,
    output logic [XLEN-1:0]     instr_o
);

    always_comb begin
        instr_o = '0;
        case (fmt_i)
            FMT_R: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: begin
                instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                // Shift-immediates carry funct7 above the 5-bit shamt
                if (opcode_i == OP_IMM && (funct3_i == 3'b001 || funct3_i == 3'b101)) begin
                    instr_o[31:25] = funct7_i;
                end
            end
            FMT_S: instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                              imm_i[4:1], imm_i[11], opcode_i};
            FMT_U: instr_o = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default: instr_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// Instruction encoder and IMEM loader: accepts field bundles, writes packed words to
// consecutive addresses with one cycle of latency.
module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int unsigned IMEM_AW = 10
) (
    input  logic                clock_i,
    input  logic                n_reset_i,
    input  logic                start_i,
    input  logic                finish_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [OP_W-1:0]     opcode_i,
    input  logic [FUNCT3_W-1:0] funct3_i,
    input  logic [FUNCT7_W-1:0] funct7_i,
    input  logic [ADDR_W-1:0]   rs1_i,
    input  logic [ADDR_W-1:0]   rs2_i,
    input  logic [ADDR_W-1:0]   rd_i,
    input  logic [XLEN-1:0]     imm_i,
    output logic                mem_we_o,
    output logic [IMEM_AW-1:0]  mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    output logic [IMEM_AW:0]    count_o,
    output logic                full_o,
    output logic                illegal_o
);

    load_state_t        state_q;
    logic [IMEM_AW-1:0] ptr_q, ptr_base;
    logic [IMEM_AW:0]   count_q, count_base;
    logic               full_q, illegal_q, mem_we_q;
    logic [IMEM_AW-1:0] mem_addr_q;
    logic [XLEN-1:0]    mem_wdata_q, word;
    instr_fmt_t         fmt;

    assign fmt = opcode_fmt(opcode_i);

    rv_instr_pack u_pack (
        .opcode_i (opcode_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_i     (rd_i),
        .imm_i    (imm_i),
        .fmt_i    (fmt),
        .instr_o  (word)
    );

    // A start in LOAD restarts the session, so a same-cycle beat lands at address 0
    always_comb begin
        ptr_base   = start_i ? '0 : ptr_q;
        count_base = start_i ? '0 : count_q;
    end

    always_ff @(posedge clock_i) begin
        if (!n_reset_i) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            illegal_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q   <= StLoad;
                        ptr_q     <= '0;
                        count_q   <= '0;
                        full_q    <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                StLoad: begin
                    ptr_q   <= ptr_base;
                    count_q <= count_base;
                    if (finish_i && !start_i) state_q <= StIdle;
                    if (in_valid_i) begin
                        if (fmt == FMT_BAD) begin
                            state_q   <= StError;
                            illegal_q <= 1'b1;
                        end else begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= ptr_base;
                            mem_wdata_q <= word;
                            ptr_q       <= ptr_base + IMEM_AW'(1);
                            count_q     <= count_base + (IMEM_AW + 1)'(1);
                            if (ptr_base == '1 && (start_i || !finish_i)) begin
                                state_q <= StFull;
                                full_q  <= 1'b1;
                            end
                        end
                    end
                end
                StFull: begin
                    if (start_i) begin
                        state_q <= StLoad;
                        ptr_q   <= '0;
                        count_q <= '0;
                        full_q  <= 1'b0;
                    end else if (finish_i) begin
                        state_q <= StIdle;
                    end
                end
                StError: begin
                    if (start_i) begin
                        state_q   <= StLoad;
                        ptr_q     <= '0;
                        count_q   <= '0;
                        illegal_q <= 1'b0;
                    end else if (finish_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = (state_q == StLoad);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign count_o     = count_q;
    assign full_o      = full_q;
    assign illegal_o   = illegal_q;

endmodule

// File: doc/rv_instr_encoder.md
# rv_instr_encoder

Sequential RV32IM instruction encoder and instruction-memory loader: the inverse of the instruction field decoder. It accepts decoded fields (opcode, funct3, funct7, rs1, rs2, rd, immediate) over a valid/ready handshake and packs them into 32-bit instruction words according to the opcode's format. It writes each word to consecutive instruction-memory addresses. It sits between the testbench/boot loader and the instruction memory of the single-cycle core.

## Interface
- XLEN, 32, instruction/data width
- OP_W, 7, opcode width
- FUNCT3_W, 3, funct3 width
- FUNCT7_W, 7, funct7 width
- ADDR_W, 5, register address width
- IMEM_AW, 10, instruction-memory word-address width
- clock  in  1  system clock, all state updates on rising edge
- n_reset  in  1  reset, synchronous, active-low
- start  in  1  begin a load session, write pointer cleared to 0
- finish  in  1  end the session, return to IDLE
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- opcode / funct3 / funct7  in  OP_W / FUNCT3_W / FUNCT7_W  instruction fields
- rs1 / rs2 / rd  in  ADDR_W each  register fields
- imm  in  XLEN  sign-extended immediate; byte offset for B/J formats, full value for U format
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  IMEM_AW  word address of the write
- mem_wdata  out  XLEN  encoded instruction
- count  out  IMEM_AW+1  words written this session
- full  out  1  memory filled
- illegal  out  1  unsupported opcode received, sticky

## Operation
- States: IDLE, LOAD, FULL, ERROR. Reset state is IDLE.
- IDLE: start → LOAD with pointer=0 and count=0.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - The opcode selects the format:
    - R: 0110011
    - I: 0010011, 0000011, 1100111, 1110011, 0001111
    - S: 0100011
    - B: 1100011
    - U: 0110111, 0010111
    - J: 1101111
  - Packing by format:
    - R: {funct7, rs2, rs1, funct3, rd, opcode}
    - I: {imm[11:0], rs1, funct3, rd, opcode}. For OP-IMM with funct3 001 or 101, bits [31:25]=funct7 and [24:20]=imm[4:0].
    - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
    - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
    - U: {imm[31:12], rd, opcode}
    - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Unused fields are ignored. imm[0] is ignored for B and J.
  - An unsupported opcode → ERROR, illegal=1, no write.
  - When the accepted beat writes address 2^IMEM_AW−1 → FULL.
- FULL: in_ready=0, full=1. start → LOAD (pointer=0, count=0, full cleared). finish → IDLE.
- ERROR: in_ready=0. start → LOAD and clears illegal. finish → IDLE with illegal held until the next start.
- finish in LOAD → IDLE. A beat accepted in the same cycle as finish is still written.
- Simultaneous start and finish: start wins.
- start in LOAD restarts the session at pointer 0. A beat in the same cycle is written to address 0 and count becomes 1.
- Reset mid-session abandons the session. A pending write is dropped.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, illegal=0.
- Latency 1: the beat accepted at edge N produces mem_we=1 with mem_addr/mem_wdata during cycle N+1 (registered outputs).
- mem_we is a one-cycle pulse per beat. Throughput is one word per cycle. The memory is always ready.
- count and the pointer increment at the acceptance edge. mem_addr shows the pre-increment pointer.
- full and illegal assert in the cycle after the offending or last beat, together with the final mem_we for full.
- in_ready is a function of state only, with no combinational path from in_valid.

## Structure
- Shared package rv_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL)
  - the instr_fmt_t enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD}
  - the load-state enum
- The decoder reuses the same opcode constants.
- One combinational sub-module, rv_instr_pack: fields + format → 32-bit word. The top holds the FSM, pointer, counter and output register.

## Test plan
- add x3,x1,x2 (0110011, f3=0, f7=0) after start → mem_we at cycle+1, addr 0, wdata 0x002081B3, count=1.
- addi x1,x0,-1 then sw x2,8(x1) on back-to-back cycles → 0xFFF00093 at addr 0, 0x0020A423 at addr 1.
- beq x0,x0,-4; jal x1,8; lui x5 with imm 0x12345000 → 0xFE000EE3, 0x008000EF, 0x123452B7.
- IMEM_AW=2, 5 beats streamed → 4 writes (addr 0–3), full=1 after the 4th write, in_ready=0, 5th beat not accepted.
- opcode 0x7F mid-stream → no write, illegal=1 sticky, in_ready=0. start → LOAD at addr 0, illegal=0.
- n_reset low during streaming → all outputs at reset values on the next edge. The pending write is not issued.
